dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter and access sequencer for the single-ported data memory (DM). It shares the DM between the CPU load/store port (port 0) and a secondary requester such as a debug/DMA loader (port 1). It serialises their accesses with round-robin fairness and rejects misaligned or out-of-range accesses before they reach the array. It sits between the MEM stage / loader and the DM, and drives the DM's address, data, store-enable, access type and pc inputs.

## Interface
Parameters:
- ADDR_LIMIT, 32'h0000_7FFF: highest legal byte address. The DM is 8192 words.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge
- clr_n  in  1  reset, asynchronous, active-low
- pN_req  in  1  request from port N (N=0,1); held with its command stable until pN_ack
- pN_we  in  1  1 = store, 0 = load
- pN_type  in  2  access type: 00 word, 01 byte, 10 byte-unsigned, 11 halfword
- pN_addr  in  32  byte address
- pN_wdata  in  32  store data; bytes/halfwords in low bits
- pN_pc  in  32  pc of the issuing instruction, forwarded for the store log
- pN_ack  out  1  one-cycle completion pulse
- pN_err  out  1  valid with pN_ack; access rejected, no memory effect
- pN_rdata  out  32  load result, valid with pN_ack
- mem_A  out  32  DM address
- mem_D  out  32  DM store data. Drives both the DM word-data and sub-word-data inputs.
- mem_str  out  1  DM store enable
- mem_type  out  2  DM access type
- mem_pc  out  32  DM pc
- mem_rdata  in  32  DM read data, combinational from mem_A/mem_type

## Operation
FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any pN_req=1: pick a winner, latch its command into the mem_* registers and into win, then go to ISSUE.
- Arbitration: register `last` holds the most recently granted port.
  - Single request: that port wins.
  - Both request: the port != last wins.
  - `last` updates on every grant.
- Legality check at grant. The request is illegal if any of:
  - addr > ADDR_LIMIT
  - word with addr[1:0] != 0
  - halfword with addr[0] != 0
  - we=1 with type=10
  - Illegal: latch err=1 and force mem_str=0 for the access.
- ISSUE (exactly one cycle):
  - mem_str = we & ~err. The DM performs the write at the closing edge.
  - At the closing edge:
    - rdata_reg <= err ? 0 : (we ? 0 : mem_rdata)
    - pwin_ack <= 1
    - go to DONE.
- DONE:
  - pwin_ack=1 and pwin_err=err for this cycle only; pwin_rdata=rdata_reg.
  - The acked port is excluded from arbitration this cycle; its req may still be high.
  - Other port requesting: grant it directly (DONE -> ISSUE). Otherwise -> IDLE.
- Non-winning port: ack=0, err=0, rdata holds its last value.
- mem_* hold their last values outside ISSUE, except mem_str, which is 0 outside ISSUE.

## Timing
- Reset (clr_n=0, immediate):
  - state = IDLE, last = 1 (port 0 wins the first tie).
  - All outputs 0: pN_ack, pN_err, pN_rdata, mem_A, mem_D, mem_str, mem_type, mem_pc.
- Latency:
  - req sampled at edge E, so ISSUE occupies cycle E..E+1 and ack is high in cycle E+1..E+2.
  - Sustained throughput is one access per 2 cycles for back-to-back alternation.
- Handshake:
  - A requester must hold req and its command until it sees ack.
  - It must drop req, or present a new command, in the cycle after ack.
  - The arbiter never samples pN_* outside the grant edge.
- Simultaneous requests in IDLE: round-robin per `last`.
  - Worst-case wait for a continuously requesting port is one foreign access, 2 cycles.
- Reset mid-ISSUE:
  - mem_str drops asynchronously; no write occurs if clr_n is low at the edge.
  - No ack is produced.
- mem_A is the full byte address. Sub-word lane selection is done by the DM.

## Test plan
- Reset, then p0 stores word 0x1234_5678 at 0x10. Required:
  - mem_str=1 for exactly one cycle.
  - p0_ack one cycle later, p0_err=0.
  - A subsequent p0 load of 0x10 returns 0x1234_5678.
- p0 and p1 both request loads in the same cycle, held continuously. Required:
  - Grants alternate p0, p1, p0, p1, with acks two cycles apart.
  - Never two acks in one cycle.
- p1 stores byte 0xAB at 0x13 over word 0x1122_3344. A p1 load-byte of 0x13 then returns 0xFFFF_FFAB; load-byte-unsigned returns 0x0000_00AB.
- p0 requests:
  - word at 0x6 -> err=1
  - halfword at 0x5 -> err=1
  - store type 10 -> err=1
  - addr 0x8000 -> err=1
  - In all four cases mem_str stays 0, rdata=0 and memory is unchanged.
- p0 store in flight (state ISSUE), clr_n pulsed low before the edge. Required:
  - The target word is unchanged and no ack is produced.
  - All outputs are 0 while reset is held.
  - After release, the first tie is won by p0.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Bundle of signals between the two DM requesters, the arbiter and the data memory.
// Latency: none (wires only).
// Backpressure: requesters hold pN_req and their command until pN_ack.
//
// slave  : arbiter side (takes requests and mem_rdata, drives acks and mem_*)
// master : requester / memory side (drives requests and mem_rdata, observes the rest)
interface dm_arbiter_if;
  // port 0 (CPU load/store)
  logic        p0_req;
  logic        p0_we;
  logic [1:0]  p0_type;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [31:0] p0_pc;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;
  // port 1 (debug / DMA loader)
  logic        p1_req;
  logic        p1_we;
  logic [1:0]  p1_type;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [31:0] p1_pc;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;
  // data memory side
  logic [31:0] mem_A;
  logic [31:0] mem_D;
  logic        mem_str;
  logic [1:0]  mem_type;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_type, p0_addr, p0_wdata, p0_pc,
    input  p1_req, p1_we, p1_type, p1_addr, p1_wdata, p1_pc,
    input  mem_rdata,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_A, mem_D, mem_str, mem_type, mem_pc
  );

  modport master (
    output p0_req, p0_we, p0_type, p0_addr, p0_wdata, p0_pc,
    output p1_req, p1_we, p1_type, p1_addr, p1_wdata, p1_pc,
    output mem_rdata,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_A, mem_D, mem_str, mem_type, mem_pc
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of the single-ported DM.
// Latency: request sampled at edge E -> ISSUE cycle E..E+1 -> ack pulse in cycle E+1..E+2.
// Backpressure: requests are held until ack; one access every 2 cycles at most.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   clr_n  : asynchronous active-low reset
//   bus    : dm_arbiter_if.slave -- pN_* request/ack for both ports and mem_* to the DM
// Parameter ADDR_LIMIT is the highest legal byte address.
module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_7FFF
) (
  input  logic        clk,
  input  logic        clr_n,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } cmd_t;

  localparam logic [1:0] T_WORD  = 2'b00;
  localparam logic [1:0] T_BYTEU = 2'b10;
  localparam logic [1:0] T_HALF  = 2'b11;

  state_t           state_q;
  logic             last_q;      // most recently granted port
  logic             win_q;       // port owning the access in flight
  logic             err_q;       // in-flight access was rejected
  logic             we_q;
  logic             mem_str_q;
  logic [31:0]      mem_A_q;
  logic [31:0]      mem_D_q;
  logic [31:0]      mem_pc_q;
  logic [1:0]       mem_type_q;
  logic [1:0]       ack_q;
  logic [1:0]       perr_q;
  logic [1:0][31:0] rdata_q;

  logic             grant_vld_d;
  logic             grant_sel_d;
  logic             illegal_d;
  cmd_t             cmd0;
  cmd_t             cmd1;
  cmd_t             cmd_d;
  logic [31:0]      rdata_d;

  assign cmd0 = {bus.p0_we, bus.p0_type, bus.p0_addr, bus.p0_wdata, bus.p0_pc};
  assign cmd1 = {bus.p1_we, bus.p1_type, bus.p1_addr, bus.p1_wdata, bus.p1_pc};

  // Grant decision. From DONE the port just acked is masked off, so a
  // requester that keeps req high across its ack cannot win twice in a row.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_sel_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_vld_d = bus.p0_req | bus.p1_req;
        if (bus.p0_req && bus.p1_req) grant_sel_d = ~last_q;
        else                          grant_sel_d = bus.p1_req;
      end
      DONE: begin
        grant_sel_d = ~win_q;
        grant_vld_d = win_q ? bus.p0_req : bus.p1_req;
      end
      default: ;
    endcase
  end

  assign cmd_d = grant_sel_d ? cmd1 : cmd0;

  always_comb begin
    illegal_d = 1'b0;
    if (cmd_d.addr > ADDR_LIMIT)                           illegal_d = 1'b1;
    if (cmd_d.typ == T_WORD && cmd_d.addr[1:0] != 2'b00)   illegal_d = 1'b1;
    if (cmd_d.typ == T_HALF && cmd_d.addr[0])              illegal_d = 1'b1;
    if (cmd_d.we && cmd_d.typ == T_BYTEU)                  illegal_d = 1'b1;
  end

  // Stores and rejected accesses return zero.
  assign rdata_d = (err_q || we_q) ? 32'h0 : bus.mem_rdata;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;   // port 0 wins the first tie
      win_q      <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      mem_str_q  <= 1'b0;
      mem_A_q    <= 32'h0;
      mem_D_q    <= 32'h0;
      mem_pc_q   <= 32'h0;
      mem_type_q <= 2'b00;
      ack_q      <= 2'b00;
      perr_q     <= 2'b00;
      rdata_q    <= '0;
    end else begin
      // ack/err are single-cycle pulses; the store strobe lives only in ISSUE
      ack_q     <= 2'b00;
      perr_q    <= 2'b00;
      mem_str_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (grant_vld_d) begin
            state_q    <= ISSUE;
            last_q     <= grant_sel_d;
            win_q      <= grant_sel_d;
            err_q      <= illegal_d;
            we_q       <= cmd_d.we;
            mem_A_q    <= cmd_d.addr;
            mem_D_q    <= cmd_d.wdata;
            mem_pc_q   <= cmd_d.pc;
            mem_type_q <= cmd_d.typ;
            mem_str_q  <= cmd_d.we & ~illegal_d;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          // the DM commits the store at this same edge
          rdata_q[win_q] <= rdata_d;
          ack_q[win_q]   <= 1'b1;
          perr_q[win_q]  <= err_q;
          state_q        <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.p0_ack   = ack_q[0];
  assign bus.p0_err   = perr_q[0];
  assign bus.p0_rdata = rdata_q[0];
  assign bus.p1_ack   = ack_q[1];
  assign bus.p1_err   = perr_q[1];
  assign bus.p1_rdata = rdata_q[1];
  assign bus.mem_A    = mem_A_q;
  assign bus.mem_D    = mem_D_q;
  assign bus.mem_str  = mem_str_q;
  assign bus.mem_type = mem_type_q;
  assign bus.mem_pc   = mem_pc_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: behavioural DM model, per-port expected-result queues.
// Latency: n/a.
// Backpressure: requests held until ack, dropped the cycle after.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic clr_n;

  dm_arbiter_if bus();

  dm_arbiter #(.ADDR_LIMIT(32'h0000_7FFF)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- DM model ----------------
  logic [31:0] dm [0:8191];
  logic [31:0] dm_w;
  logic [7:0]  dm_b;
  logic [15:0] dm_h;

  always_comb begin
    dm_w = dm[bus.mem_A[14:2]];
    dm_b = dm_w[8*bus.mem_A[1:0] +: 8];
    dm_h = dm_w[16*bus.mem_A[1] +: 16];
    case (bus.mem_type)
      2'b00:   bus.mem_rdata = dm_w;
      2'b01:   bus.mem_rdata = {{24{dm_b[7]}}, dm_b};
      2'b10:   bus.mem_rdata = {24'h0, dm_b};
      default: bus.mem_rdata = {{16{dm_h[15]}}, dm_h};
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_str) begin
      case (bus.mem_type)
        2'b00:   dm[bus.mem_A[14:2]] <= bus.mem_D;
        2'b11:   dm[bus.mem_A[14:2]][16*bus.mem_A[1] +: 16] <= bus.mem_D[15:0];
        default: dm[bus.mem_A[14:2]][8*bus.mem_A[1:0] +: 8] <= bus.mem_D[7:0];
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          cyc = 0;
  int          str_cnt = 0;
  int          str_cyc = 0;
  int          ack_cyc = 0;
  logic [31:0] cap_A, cap_D, cap_pc;
  bit          log_en = 0;
  int          log_port[$];
  int          log_cyc[$];

  task automatic push_exp(input int p, input logic e, input logic [31:0] rd);
    exp_t x;
    x.err = e;
    x.rd  = rd;
    if (p == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic sb_pop(input int p, input logic e, input logic [31:0] rd);
    exp_t x;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      chk($sformatf("unexpected_ack_p%0d", p), 32'd1, 32'd0);
    end else begin
      x = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("err_p%0d", p), {31'h0, e}, {31'h0, x.err});
      chk($sformatf("rdata_p%0d", p), rd, x.rd);
    end
    ack_cyc = cyc;
    if (log_en) begin
      log_port.push_back(p);
      log_cyc.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    if (clr_n) begin
      cyc++;
      if (bus.mem_str) begin
        str_cnt++;
        str_cyc = cyc;
        cap_A   = bus.mem_A;
        cap_D   = bus.mem_D;
        cap_pc  = bus.mem_pc;
      end
      if (bus.p0_ack || bus.p1_ack)
        chk("single_ack", {31'h0, bus.p0_ack & bus.p1_ack}, 32'h0);
      if (bus.p0_ack) sb_pop(0, bus.p0_err, bus.p0_rdata);
      if (bus.p1_ack) sb_pop(1, bus.p1_err, bus.p1_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cmd(input int p, input logic we, input logic [1:0] ty,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_type = ty;
      bus.p0_addr = a; bus.p0_wdata = d; bus.p0_pc = 32'h1000 | a;
    end else begin
      bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_type = ty;
      bus.p1_addr = a; bus.p1_wdata = d; bus.p1_pc = 32'h1000 | a;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.p0_req = 1'b0;
    else        bus.p1_req = 1'b0;
  endtask

  task automatic wait_ack(input int p, output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.p0_ack : bus.p1_ack) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk($sformatf("ack_timeout_p%0d", p), 32'd0, 32'd1);
  endtask

  task automatic access(input string tag, input int p, input logic we, input logic [1:0] ty,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd);
    bit ok;
    int e_str;
    e_str = (we && !e_err) ? 1 : 0;
    @(posedge clk); #1;
    str_cnt = 0;
    set_cmd(p, we, ty, a, d);
    push_exp(p, e_err, e_rd);
    wait_ack(p, ok);
    @(posedge clk); #1;
    drop(p);
    chk({tag, "_str_cycles"}, str_cnt, e_str);
    if (ok && e_str == 1) begin
      chk({tag, "_ack_after_str"}, ack_cyc - str_cyc, 32'd1);
      chk({tag, "_mem_A"}, cap_A, a);
      chk({tag, "_mem_D"}, cap_D, d);
      chk({tag, "_mem_pc"}, cap_pc, 32'h1000 | a);
    end
  endtask

  task automatic hold_loads(input int p, input logic [31:0] a, input logic [31:0] e_rd, input int n);
    bit ok;
    @(posedge clk); #1;
    set_cmd(p, 1'b0, 2'b00, a, 32'h0);
    for (int k = 0; k < n; k++) push_exp(p, 1'b0, e_rd);
    for (int k = 0; k < n; k++) begin
      wait_ack(p, ok);
      if (!ok) break;
    end
    @(posedge clk); #1;
    drop(p);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {25'h0, bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err,
                        bus.mem_str, bus.mem_type}, 32'h0);
    chk({tag, "_p0_rdata"}, bus.p0_rdata, 32'h0);
    chk({tag, "_p1_rdata"}, bus.p1_rdata, 32'h0);
    chk({tag, "_mem_A"}, bus.mem_A, 32'h0);
    chk({tag, "_mem_D"}, bus.mem_D, 32'h0);
    chk({tag, "_mem_pc"}, bus.mem_pc, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] saved;
    int          first;
    bit          ok;

    for (int i = 0; i < 8192; i++) dm[i] = {16'hC0DE, 16'(i)};
    clr_n = 1'b0;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_type = 0; bus.p0_addr = 0; bus.p0_wdata = 0; bus.p0_pc = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_type = 0; bus.p1_addr = 0; bus.p1_wdata = 0; bus.p1_pc = 0;
    #12;
    check_zero("reset");
    @(negedge clk);
    clr_n = 1'b1;

    // word store then load back on port 0
    access("p0_sw",   0, 1'b1, 2'b00, 32'h10, 32'h1234_5678, 1'b0, 32'h0);
    access("p0_lw",   0, 1'b0, 2'b00, 32'h10, 32'h0,         1'b0, 32'h1234_5678);

    // sub-word store and sign/zero-extended loads on port 1
    access("p1_sw",   1, 1'b1, 2'b00, 32'h10, 32'h1122_3344, 1'b0, 32'h0);
    access("p1_sb",   1, 1'b1, 2'b01, 32'h13, 32'h0000_00AB, 1'b0, 32'h0);
    access("p1_lb",   1, 1'b0, 2'b01, 32'h13, 32'h0,         1'b0, 32'hFFFF_FFAB);
    access("p1_lh",   1, 1'b0, 2'b11, 32'h12, 32'h0,         1'b0, 32'hFFFF_AB22);
    access("p1_lbu",  1, 1'b0, 2'b10, 32'h13, 32'h0,         1'b0, 32'h0000_00AB);

    // both ports loading continuously; last grant was port 1, so port 0 leads
    log_en = 1;
    fork
      hold_loads(0, 32'h10, 32'hAB22_3344, 2);
      hold_loads(1, 32'h20, 32'hC0DE_0008, 2);
    join
    log_en = 0;
    chk("alt_ack_count", log_port.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_port.size(); i++) begin
      chk($sformatf("alt_port_%0d", i), log_port[i], i % 2);
      if (i > 0) chk($sformatf("alt_gap_%0d", i), log_cyc[i] - log_cyc[i-1], 32'd2);
    end

    // rejected accesses, then the highest legal word
    access("bad_word",  0, 1'b0, 2'b00, 32'h6,    32'h0,         1'b1, 32'h0);
    access("bad_half",  0, 1'b0, 2'b11, 32'h5,    32'h0,         1'b1, 32'h0);
    access("bad_st10",  0, 1'b1, 2'b10, 32'h10,   32'hDEAD_BEEF, 1'b1, 32'h0);
    access("bad_range", 0, 1'b0, 2'b00, 32'h8000, 32'h0,         1'b1, 32'h0);
    access("after_bad", 0, 1'b0, 2'b00, 32'h10,   32'h0,         1'b0, 32'hAB22_3344);
    access("top_word",  0, 1'b0, 2'b00, 32'h7FFC, 32'h0,         1'b0, 32'hC0DE_1FFF);

    // reset while a store is in ISSUE
    saved = dm[32'h40 >> 2];
    @(posedge clk); #1;
    set_cmd(0, 1'b1, 2'b00, 32'h40, 32'hFFFF_0000);
    @(posedge clk); #2;
    chk("issue_str", {31'h0, bus.mem_str}, 32'h1);
    clr_n = 1'b0;
    drop(0);
    #1;
    check_zero("rst_mid");
    repeat (2) @(negedge clk);
    check_zero("rst_held");
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_word_kept", dm[32'h40 >> 2], saved);
    chk("rst_no_pending", q0.size() + q1.size(), 32'd0);

    // first tie after reset goes to port 0
    @(posedge clk); #1;
    set_cmd(0, 1'b0, 2'b00, 32'h40, 32'h0);
    set_cmd(1, 1'b0, 2'b00, 32'h44, 32'h0);
    push_exp(0, 1'b0, saved);
    push_exp(1, 1'b0, 32'hC0DE_0011);
    first = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.p0_ack) begin first = 0; break; end
      if (bus.p1_ack) begin first = 1; break; end
    end
    chk("tie_winner", first, 32'd0);
    @(posedge clk); #1;
    drop(0);
    wait_ack(1, ok);
    @(posedge clk); #1;
    drop(1);
    repeat (3) @(negedge clk);
    chk("final_queues_empty", q0.size() + q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
